// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (cpu / dbg) arbiter in front of a single shared memory
// with a fixed read latency. Three-state FSM IDLE -> BUSY -> DONE.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate grants on
// simultaneous requests; otherwise the CPU port has fixed priority.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_dbg
);

  // Out-of-range latencies fall back to a single cycle.
  localparam int unsigned LAT_EFF = ((LATENCY >= 1) && (LATENCY <= 15)) ? LATENCY : 1;
  localparam logic [3:0]  LAT_CNT = 4'(LAT_EFF);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              grant_dbg_q, grant_dbg_d;
  logic              pick_dbg;

  // Winner selection for a request seen in IDLE.
  always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_dbg = dbg_req && (!cpu_req || !grant_dbg_q);
`else
    pick_dbg = dbg_req && !cpu_req;
`endif
  end

  // Next-state logic: latch the winner's request, count latency, capture read data.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_dbg_d = grant_dbg_q;
    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          grant_dbg_d = pick_dbg;
          we_d        = pick_dbg ? dbg_we    : cpu_we;
          addr_d      = pick_dbg ? dbg_addr  : cpu_addr;
          wdata_d     = pick_dbg ? dbg_wdata : cpu_wdata;
          cnt_d       = LAT_CNT;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = DONE;
          if (!we_q) begin
            if (grant_dbg_q) dbg_rdata_d = mem_rdata;
            else             cpu_rdata_d = mem_rdata;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; reset also aborts any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      grant_dbg_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      grant_dbg_q <= grant_dbg_d;
    end
  end

  // Outputs decoded from state and latched request.
  always_comb begin
    busy      = (state_q != IDLE);
    mem_we    = (state_q == BUSY) && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    cpu_ack   = (state_q == DONE) && !grant_dbg_q;
    dbg_ack   = (state_q == DONE) &&  grant_dbg_q;
    cpu_rdata = cpu_rdata_q;
    dbg_rdata = dbg_rdata_q;
    grant_dbg = grant_dbg_q;
  end

endmodule
